// File: rtl/matmul_operand_sp.sv
// Operand scratchpad for the matmul calc unit: A/B/C read ports, C write-back burst tracking, host port.
// Optional SP_WRITE_BYPASS_EN: same-cycle calc write forwarded to reads (write-first).
module matmul_operand_sp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] address_a_i,
  input  logic [ADDR_WIDTH-1:0] address_b_i,
  input  logic [ADDR_WIDTH-1:0] address_c_i,
  output logic [BUS_WIDTH-1:0]  data_a_o,
  output logic [BUS_WIDTH-1:0]  data_b_o,
  output logic [BUS_WIDTH-1:0]  data_c_o,
  input  logic                  enable_w_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [BUS_WIDTH-1:0]  data_i,
  input  logic                  host_wr_i,
  input  logic                  host_rd_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [BUS_WIDTH-1:0]  host_wdata_i,
  output logic                  host_ready_o,
  output logic [BUS_WIDTH-1:0]  host_rdata_o,
  output logic                  host_rvalid_o,
  input  logic                  clear_i,
  output logic [$clog2((BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)):0] c_wr_count_o,
  output logic                  c_done_o,
  output logic                  addr_err_o
);
  localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned C_WORDS = MAX_DIM * MAX_DIM;
  localparam int unsigned IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int unsigned C_IDX_W = 2 * IDX_W;
  localparam int unsigned CNT_W   = $clog2(C_WORDS) + 1;

  typedef enum logic [1:0] {OP_NONE, OP_A, OP_B, OP_C} op_e;
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_e;

  logic [BUS_WIDTH-1:0] mem_a [MAX_DIM];
  logic [BUS_WIDTH-1:0] mem_b [MAX_DIM];
  logic [BUS_WIDTH-1:0] mem_c [C_WORDS];
  state_e state;

  function automatic op_e decode(input logic [ADDR_WIDTH-1:0] addr);
    case (addr[4:0])
      5'b00100: return OP_A;
      5'b01000: return OP_B;
      5'b10000: return OP_C;
      default:  return OP_NONE;
    endcase
  endfunction

  // Index compares are equality-based so an unknown address selects nothing and reads 0.
  function automatic logic [BUS_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] addr);
    logic [BUS_WIDTH-1:0] w;
    w = '0;
    case (decode(addr))
      OP_A: for (int i = 0; i < MAX_DIM; i++) if (addr[5 +: IDX_W] == IDX_W'(i)) w = mem_a[i];
      OP_B: for (int i = 0; i < MAX_DIM; i++) if (addr[5 +: IDX_W] == IDX_W'(i)) w = mem_b[i];
      OP_C: for (int i = 0; i < C_WORDS; i++) if (addr[5 +: C_IDX_W] == C_IDX_W'(i)) w = mem_c[i];
      default: w = '0;
    endcase
    return w;
  endfunction

`ifdef SP_WRITE_BYPASS_EN
  function automatic logic same_word(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    if (decode(a) != decode(b) || decode(a) == OP_NONE) return 1'b0;
    if (decode(a) == OP_C) return a[5 +: C_IDX_W] == b[5 +: C_IDX_W];
    return a[5 +: IDX_W] == b[5 +: IDX_W];
  endfunction
`endif

  function automatic logic [BUS_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [BUS_WIDTH-1:0] w;
    w = lookup(addr);
`ifdef SP_WRITE_BYPASS_EN
    if (enable_w_i && same_word(addr, address_i)) w = data_i;
`endif
    return w;
  endfunction

  // Calc unit always wins the single write path.
  logic                  host_wr_acc_c, host_rd_acc_c, wr_en_c, wr_err_c, calc_c_wr_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [BUS_WIDTH-1:0]  wr_data_c;
  op_e                   wr_op_c;

  assign host_ready_o = ~enable_w_i;

  always_comb begin
    host_wr_acc_c = host_wr_i & ~enable_w_i;
    host_rd_acc_c = host_rd_i & ~host_wr_i & ~enable_w_i;
    wr_en_c       = enable_w_i | host_wr_acc_c;
    wr_addr_c     = enable_w_i ? address_i : host_addr_i;
    wr_data_c     = enable_w_i ? data_i : host_wdata_i;
    wr_op_c       = decode(wr_addr_c);
    wr_err_c      = wr_en_c && (wr_op_c == OP_NONE);
    calc_c_wr_c   = enable_w_i && (decode(address_i) == OP_C);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
      for (int i = 0; i < C_WORDS; i++) mem_c[i] <= '0;
    end else if (wr_en_c) begin
      case (wr_op_c)
        OP_A: for (int i = 0; i < MAX_DIM; i++) if (wr_addr_c[5 +: IDX_W] == IDX_W'(i)) mem_a[i] <= wr_data_c;
        OP_B: for (int i = 0; i < MAX_DIM; i++) if (wr_addr_c[5 +: IDX_W] == IDX_W'(i)) mem_b[i] <= wr_data_c;
        OP_C: for (int i = 0; i < C_WORDS; i++) if (wr_addr_c[5 +: C_IDX_W] == C_IDX_W'(i)) mem_c[i] <= wr_data_c;
        default: ;
      endcase
    end
  end

  // Read ports, host response, error flag and write-back burst tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_a_o      <= '0;
      data_b_o      <= '0;
      data_c_o      <= '0;
      host_rdata_o  <= '0;
      host_rvalid_o <= 1'b0;
      c_wr_count_o  <= '0;
      c_done_o      <= 1'b0;
      addr_err_o    <= 1'b0;
      state         <= S_IDLE;
    end else begin
      data_a_o      <= read_port(address_a_i);
      data_b_o      <= read_port(address_b_i);
      data_c_o      <= read_port(address_c_i);
      host_rvalid_o <= host_rd_acc_c;
      if (host_rd_acc_c) host_rdata_o <= read_port(host_addr_i);
      c_done_o <= 1'b0;
      if (clear_i) begin
        addr_err_o   <= 1'b0;
        c_wr_count_o <= '0;
        state        <= S_IDLE;
      end else begin
        if (wr_err_c) addr_err_o <= 1'b1;
        case (state)
          S_BURST: begin
            if (calc_c_wr_c) begin
              c_wr_count_o <= CNT_W'(c_wr_count_o + 1'b1);
              if (c_wr_count_o == CNT_W'(C_WORDS - 1)) begin
                state    <= S_DONE;
                c_done_o <= 1'b1;
              end
            end
          end
          default: begin
            // A C write arriving in IDLE or DONE opens a new burst.
            if (calc_c_wr_c) begin
              c_wr_count_o <= CNT_W'(1);
              state        <= S_BURST;
            end else begin
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_a_i[ADDR_WIDTH-1:5+C_IDX_W], address_b_i[ADDR_WIDTH-1:5+C_IDX_W],
                              address_c_i[ADDR_WIDTH-1:5+C_IDX_W], address_i[ADDR_WIDTH-1:5+C_IDX_W],
                              host_addr_i[ADDR_WIDTH-1:5+C_IDX_W]};
endmodule
